alu32_nibble_seq: RTL and testbench
===================================

ALU32_NIBBLE_SEQ -- requirements
Module: alu32_nibble_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4, from 8 to 64.
REQ-002 The block SHALL derive local constant NIBBLES = WIDTH/4, the number of adder passes per operation.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, operation request; it is sampled only in IDLE or DONE.
REQ-006 The block SHALL have port op, input, 1, operation select: 0 = a+b, 1 = a-b.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while in RUN.
REQ-009 The block SHALL have port done, output, 1, high for exactly one cycle in DONE.
REQ-010 The block SHALL have port result, output, WIDTH, the registered sum or difference.
REQ-011 The block SHALL have ports flag_c, flag_v, flag_n and flag_z, output, 1 each: carry, signed overflow, negative and zero.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 SHALL latch a, b and op, clear the nibble counter, set carry_reg to op, and enter RUN.
REQ-014 The FSM SHALL move from DONE to IDLE when start=0.
REQ-015 start during RUN SHALL be ignored, with no queueing and no effect on the operation in progress.
REQ-016 In RUN, each cycle SHALL apply one 4-bit adder pass to nibble cnt of a_reg and of b_reg^{4{op_reg}}, with carry-in carry_reg.
REQ-017 Each RUN edge SHALL write the pass sum into result[4*cnt+3:4*cnt], update carry_reg from co, and increment cnt.
REQ-018 On the RUN edge with cnt = NIBBLES-1, the block SHALL register flag_c = co, flag_v = c3 XOR co, flag_n = final result MSB and flag_z = (final result == 0), then enter DONE.
REQ-019 Latency SHALL be exactly NIBBLES clock edges from the edge sampling start to the first cycle with done=1 (8 for WIDTH=32).
REQ-020 Back-to-back throughput SHALL be one operation per NIBBLES+1 cycles, achieved by a start accepted in DONE.
REQ-021 result and the flags SHALL hold their values from done until the next start is accepted.
REQ-022 During RUN, result SHALL hold partial nibbles and SHALL NOT be consumed before done.
REQ-023 Subtraction SHALL follow two's complement: flag_c=1 means no borrow; flag_v follows signed overflow of a-b.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH; the carry-out appears only in flag_c.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, cnt=0, carry_reg=0, busy=0, done=0, result=0 and all flags=0.
REQ-026 Reset SHALL take priority over start.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse; the next start after reset is released SHALL run normally.

Structure
REQ-028 State encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) SHALL live in the shared ALU package/include, alongside the op encodings ALU_ADD=1'b0 and ALU_SUB=1'b1.
REQ-029 The block SHALL instantiate exactly one cla4_ov as its adder sub-module, using its c3 and co outputs.
REQ-030 Nibble selection SHALL be an indexed part-select; no per-nibble adder replication SHALL be used.

Verification
REQ-031 Scenario: op=0, a=32'h7FFF_FFFF, b=1 -> done at edge 8; result=32'h8000_0000; v=1, n=1, c=0, z=0.
REQ-032 Scenario: op=0, a=32'hFFFF_FFFF, b=1 -> result=0; c=1, z=1, v=0, n=0.
REQ-033 Scenario: op=1, a=5, b=7 -> result=32'hFFFF_FFFE; c=0, n=1, v=0; op=1, a=32'h8000_0000, b=1 -> result=32'h7FFF_FFFF, v=1, c=1.
REQ-034 Scenario: start pulsed at cycles 0 and 3 -> only one done, at cycle 8; operands from cycle 0 are used.
REQ-035 Scenario: reset asserted at cycle 4 of RUN -> no done; all outputs 0 next cycle; a subsequent op 3+4 yields 7 at latency 8.
REQ-036 Scenario: back-to-back starts held high, 1000 random operands per op -> done every 9 cycles; result and flags match the golden model.

Source files
------------

// File: rtl/alu32_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit:
// the FSM state encodings and the operation select encodings.
package alu32_nibble_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/alu32_nibble_seq_cla4_ov.sv
// 4-bit carry-lookahead adder that also exposes the carry into bit 3,
// so the caller can derive signed overflow as c3 ^ co.
module cla4_ov (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = ci;
    c_s[1] = g_s[0] | (p_s[0] & ci);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & ci);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
    s      = p_s ^ c_s[3:0];
    c3     = c_s[3];
    co     = c_s[4];
  end

endmodule

// File: rtl/alu32_nibble_seq.sv
// Nibble-serial WIDTH-bit adder/subtractor: one shared 4-bit CLA pass per
// cycle, NIBBLES passes per operation, with registered result and NZCV flags.
module alu32_nibble_seq
  import alu32_nibble_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [3:0]       sum_s;
  logic             c3_s;
  logic             co_s;
  logic [WIDTH-1:0] result_nxt_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control; start is only honoured outside RUN
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Current nibble selection; subtraction inverts b and injects carry-in 1
  always_comb begin
    a_nib_s      = a_r[{cnt_r, 2'b00} +: 4];
    b_nib_s      = b_r[{cnt_r, 2'b00} +: 4] ^ {4{op_r == ALU_SUB}};
    result_nxt_s = result;
    result_nxt_s[{cnt_r, 2'b00} +: 4] = sum_s;
  end

  cla4_ov u_cla4 (
    .a  (a_nib_s),
    .b  (b_nib_s),
    .ci (carry_r),
    .s  (sum_s),
    .c3 (c3_s),
    .co (co_s)
  );

  // Operand latch, nibble accumulation, flags and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      op_r    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      carry_r <= 1'b0;
      result  <= {WIDTH{1'b0}};
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nxt_s == RUN);
      done <= (state_nxt_s == DONE);
      if (load_s) begin
        a_r     <= a;
        b_r     <= b;
        op_r    <= op;
        cnt_r   <= {CNT_W{1'b0}};
        carry_r <= op;
      end else if (step_s) begin
        result  <= result_nxt_s;
        carry_r <= co_s;
        cnt_r   <= cnt_r + CNT_W'(1);
        if (last_s) begin
          flag_c <= co_s;
          flag_v <= c3_s ^ co_s;
          flag_n <= result_nxt_s[WIDTH-1];
          flag_z <= (result_nxt_s == {WIDTH{1'b0}});
        end else begin
          flag_c <= flag_c;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_alu32_nibble_seq.sv
// Self-checking bench for alu32_nibble_seq (WIDTH=32): directed corner cases,
// start-during-RUN, reset mid-operation and a long randomized back-to-back run.
module tb_alu32_nibble_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_c;
  logic        flag_v;
  logic        flag_n;
  logic        flag_z;

  int n_tests = 0;
  int n_fail  = 0;

  alu32_nibble_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_c (flag_c),
    .flag_v (flag_v),
    .flag_n (flag_n),
    .flag_z (flag_z)
  );

  always #5 clk = ~clk;

  // Reference: {c, v, n, z, result} from whole-word arithmetic
  function automatic logic [35:0] golden(input logic [31:0] x, input logic [31:0] y,
                                         input logic o);
    logic [32:0] full;
    logic        v;
    if (o == 1'b0) begin
      full = {1'b0, x} + {1'b0, y};
      v    = (x[31] == y[31]) && (full[31] != x[31]);
    end else begin
      full = {1'b0, x} + {1'b0, ~y} + 33'd1;
      v    = (x[31] != y[31]) && (full[31] != x[31]);
    end
    return {full[32], v, full[31], (full[31:0] == 32'd0), full[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    int unsigned r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [35:0] outs();
    return {flag_c, flag_v, flag_n, flag_z, result};
  endfunction

  // Issue one operation and count edges until done (-1 on timeout)
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic o,
                        output int lat);
    a = x; b = y; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 20; k++) begin
      a = $urandom; b = $urandom; op = ~op;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = 32'h1234_5678; b = 32'h0000_0001; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, outs()} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, outs()});
    end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_priority_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_directed();
    logic [31:0] xs [6];
    logic [31:0] ys [6];
    logic        os [6];
    logic [35:0] ex [6];
    logic [35:0] held;
    int          lat;
    xs[0] = 32'h7FFF_FFFF; ys[0] = 32'd1; os[0] = 1'b0; ex[0] = {4'b0110, 32'h8000_0000};
    xs[1] = 32'hFFFF_FFFF; ys[1] = 32'd1; os[1] = 1'b0; ex[1] = {4'b1001, 32'h0000_0000};
    xs[2] = 32'd5;         ys[2] = 32'd7; os[2] = 1'b1; ex[2] = {4'b0010, 32'hFFFF_FFFE};
    xs[3] = 32'h8000_0000; ys[3] = 32'd1; os[3] = 1'b1; ex[3] = {4'b1100, 32'h7FFF_FFFF};
    xs[4] = 32'd9;         ys[4] = 32'd9; os[4] = 1'b1; ex[4] = {4'b1001, 32'h0000_0000};
    xs[5] = 32'h1234_5678; ys[5] = 32'h1111_1111; os[5] = 1'b0;
    ex[5] = {4'b0000, 32'h2345_6789};
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], ys[i], os[i], lat);
      n_tests++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d expected 8", i, lat);
      end
      n_tests++;
      if (outs() !== ex[i]) begin
        n_fail++;
        $display("FAIL directed_value[%0d]: got %h expected %h", i, outs(), ex[i]);
      end
      held = outs();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({done, busy, outs()} !== {2'b00, held}) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: got %h expected %h", i,
                 {done, busy, outs()}, {2'b00, held});
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] x0;
    logic [31:0] y0;
    logic [35:0] cap;
    int          ndone;
    int          first;
    x0 = $urandom; y0 = $urandom;
    a = x0; b = y0; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = -1; cap = 36'd0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        start = 1'b1; a = ~x0; b = 32'd3; op = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_in_run: got %b expected 1", busy);
        end
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = k;
          cap   = outs();
        end
      end
    end
    n_tests++;
    if (ndone !== 1 || first !== 8) begin
      n_fail++;
      $display("FAIL start_ignored_done: got count %0d at %0d expected 1 at 8", ndone, first);
    end
    n_tests++;
    if (cap !== golden(x0, y0, 1'b1)) begin
      n_fail++;
      $display("FAIL start_ignored_value: got %h expected %h", cap, golden(x0, y0, 1'b1));
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    int lat;
    a = $urandom; b = $urandom; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done, outs()} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run_outputs: got %h expected 0", {busy, done, outs()});
    end
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_run_no_done: got %0d pulses expected 0", ndone);
    end
    run_op(32'd3, 32'd4, 1'b0, lat);
    n_tests++;
    if (lat !== 8 || outs() !== {4'b0000, 32'd7}) begin
      n_fail++;
      $display("FAIL reset_recover: got lat %0d value %h expected lat 8 value %h",
               lat, outs(), {4'b0000, 32'd7});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ca;
    logic [31:0] cb;
    logic        co;
    int          gap;
    int          exp_gap;
    int          i;
    ca = pick(); cb = pick(); co = 1'b0;
    a = ca; b = cb; op = co; start = 1'b1;
    @(posedge clk); #1;
    gap = 0; exp_gap = 8; i = 0;
    while (i < 2000) begin
      @(posedge clk); #1;
      gap++;
      if (done === 1'b1) begin
        n_tests++;
        if (gap !== exp_gap) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, gap, exp_gap);
        end
        n_tests++;
        if (outs() !== golden(ca, cb, co)) begin
          n_fail++;
          $display("FAIL b2b_value[%0d]: a=%h b=%h op=%b got %h expected %h",
                   i, ca, cb, co, outs(), golden(ca, cb, co));
        end
        i++;
        exp_gap = 9; gap = 0;
        ca = pick(); cb = pick(); co = (i >= 1000);
        a = ca; b = cb; op = co;
      end else if (gap > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL b2b_timeout[%0d]: got no done in %0d cycles expected 9", i, gap);
        break;
      end else begin
        a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
